// File: rtl/mult_pipe_param_if.sv
// Request/response bundle for the pipelined multiplier: op launch, stage control and completion.
interface mult_pipe_param_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned ROB_W = 6,
   parameter int unsigned PRN_W = 7
);
   logic             enable;
   logic             flush;
   logic             start;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic             is_signed;
   logic             high_sel;
   logic [ROB_W-1:0] ROB_num_in;
   logic [PRN_W-1:0] dest_PRN_in;
   logic [WIDTH-1:0] product;
   logic [ROB_W-1:0] ROB_num_out;
   logic [PRN_W-1:0] dest_PRN_out;
   logic             done;
   logic             busy;

   modport master (
      output enable, flush, start, mcand, mplier, is_signed, high_sel, ROB_num_in, dest_PRN_in,
      input  product, ROB_num_out, dest_PRN_out, done, busy
   );

   modport slave (
      input  enable, flush, start, mcand, mplier, is_signed, high_sel, ROB_num_in, dest_PRN_in,
      output product, ROB_num_out, dest_PRN_out, done, busy
   );
endinterface

// File: rtl/mult_pipe_param.sv
// Stallable, flushable STAGES-deep multiplier; each stage folds WIDTH/STAGES multiplier bits
// into a 2*WIDTH accumulator, and the last stage registers the selected product half.
module mult_pipe_param #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4,
   parameter int unsigned ROB_W  = 6,
   parameter int unsigned PRN_W  = 7
) (
   input logic              clock,
   input logic              reset,
   mult_pipe_param_if.slave bus
);
   localparam int unsigned CHUNK = WIDTH / STAGES;
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned LAST  = STAGES - 1;
   localparam int unsigned NQ    = (STAGES > 1) ? STAGES - 1 : 1;

   typedef struct packed {
      logic             vld;
      logic [PW-1:0]    acc;
      logic [PW-1:0]    mc;
      logic [WIDTH-1:0] mp;
      logic             sgn;
      logic             hi;
      logic [ROB_W-1:0] rob;
      logic [PRN_W-1:0] prn;
   } stage_t;

   stage_t           in_c;
   stage_t           stg_d [STAGES];
   stage_t           stg_q [NQ];
   logic             busy_d;
   logic             done_q;
   logic             busy_q;
   logic [WIDTH-1:0] product_q;
   logic [ROB_W-1:0] rob_q;
   logic [PRN_W-1:0] prn_q;

   // One radix-2^CHUNK step: add the shifted multiplicand times the low multiplier digit.
   function automatic stage_t step(input stage_t s);
      stage_t r;
      r     = s;
      r.acc = s.acc + (s.mc * PW'(s.mp[CHUNK-1:0]));
      r.mc  = s.mc << CHUNK;
      r.mp  = s.mp >> CHUNK;
      return r;
   endfunction

   // Signed mode: sign-extend the multiplicand and pre-load -(mcand << WIDTH) when the
   // multiplier is negative, so the unsigned digit walk over WIDTH bits stays exact.
   always_comb begin
      in_c     = '0;
      in_c.vld = bus.start & ~bus.flush;
      in_c.mc  = {{WIDTH{bus.is_signed & bus.mcand[WIDTH-1]}}, bus.mcand};
      in_c.mp  = bus.mplier;
      in_c.acc = (bus.is_signed && bus.mplier[WIDTH-1]) ?
                 (PW'(0) - {bus.mcand, {WIDTH{1'b0}}}) : PW'(0);
      in_c.sgn = bus.is_signed;
      in_c.hi  = bus.high_sel;
      in_c.rob = bus.ROB_num_in;
      in_c.prn = bus.dest_PRN_in;
   end

   always_comb begin
      stg_d[0] = step(in_c);
      for (int k = 1; k < int'(STAGES); k++) begin
         stg_d[k] = step(stg_q[k-1]);
      end
      busy_d = 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
         busy_d = busy_d | stg_d[k].vld;
      end
   end

   // Flush outranks the stall; otherwise every register advances only on enable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < int'(NQ); k++) stg_q[k] <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         product_q <= '0;
         rob_q     <= '0;
         prn_q     <= '0;
      end else if (bus.flush) begin
         for (int k = 0; k < int'(NQ); k++) stg_q[k].vld <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else if (bus.enable) begin
         for (int k = 0; k < int'(LAST); k++) stg_q[k] <= stg_d[k];
         done_q    <= stg_d[LAST].vld;
         busy_q    <= busy_d;
         product_q <= stg_d[LAST].hi ? stg_d[LAST].acc[PW-1:WIDTH] : stg_d[LAST].acc[WIDTH-1:0];
         rob_q     <= stg_d[LAST].rob;
         prn_q     <= stg_d[LAST].prn;
      end
   end

   assign bus.done         = done_q;
   assign bus.busy         = busy_q;
   assign bus.product      = product_q;
   assign bus.ROB_num_out  = rob_q;
   assign bus.dest_PRN_out = prn_q;
endmodule

// File: tb/tb_mult_pipe_param.sv
// Directed-vector bench for mult_pipe_param: 64/4 main build plus 32/8 and 16/1 builds.
module tb_mult_pipe_param;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   mult_pipe_param_if #(.WIDTH(64), .ROB_W(6), .PRN_W(7)) bus64 ();
   mult_pipe_param_if #(.WIDTH(32), .ROB_W(6), .PRN_W(7)) bus32 ();
   mult_pipe_param_if #(.WIDTH(16), .ROB_W(6), .PRN_W(7)) bus16 ();

   mult_pipe_param #(.WIDTH(64), .STAGES(4), .ROB_W(6), .PRN_W(7))
      u_dut64 (.clock(clock), .reset(reset), .bus(bus64.slave));
   mult_pipe_param #(.WIDTH(32), .STAGES(8), .ROB_W(6), .PRN_W(7))
      u_dut32 (.clock(clock), .reset(reset), .bus(bus32.slave));
   mult_pipe_param #(.WIDTH(16), .STAGES(1), .ROB_W(6), .PRN_W(7))
      u_dut16 (.clock(clock), .reset(reset), .bus(bus16.slave));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic op64(input logic [63:0] mc, input logic [63:0] mp, input logic sgn,
                       input logic hi, input logic [5:0] rob, input logic [6:0] prn);
      bus64.start = 1'b1; bus64.mcand = mc; bus64.mplier = mp; bus64.is_signed = sgn;
      bus64.high_sel = hi; bus64.ROB_num_in = rob; bus64.dest_PRN_in = prn;
   endtask

   // Launch, then count edges (capture edge = 1) until done, bounded.
   task automatic single64(input string tag, input logic [63:0] mc, input logic [63:0] mp,
                           input logic sgn, input logic hi, input logic [5:0] rob,
                           input logic [6:0] prn, input logic [63:0] exp);
      int n;
      op64(mc, mp, sgn, hi, rob, prn);
      @(posedge clock); #1; bus64.start = 1'b0; n = 1;
      while (!bus64.done && n < 30) begin @(posedge clock); #1; n++; end
      check_eq({tag, "_lat"}, 64'(n), 64'd4);
      check_eq({tag, "_prod"}, bus64.product, exp);
      check_eq({tag, "_rob"}, 64'(bus64.ROB_num_out), 64'(rob));
      check_eq({tag, "_prn"}, 64'(bus64.dest_PRN_out), 64'(prn));
      @(posedge clock); #1;
      check_eq({tag, "_once"}, 64'(bus64.done), 64'd0);
   endtask

   task automatic single32(input string tag, input logic [31:0] mc, input logic [31:0] mp,
                           input logic sgn, input logic hi, input logic [5:0] rob,
                           input logic [31:0] exp);
      int n;
      bus32.start = 1'b1; bus32.mcand = mc; bus32.mplier = mp; bus32.is_signed = sgn;
      bus32.high_sel = hi; bus32.ROB_num_in = rob; bus32.dest_PRN_in = 7'(rob);
      @(posedge clock); #1; bus32.start = 1'b0; n = 1;
      while (!bus32.done && n < 30) begin @(posedge clock); #1; n++; end
      check_eq({tag, "_lat"}, 64'(n), 64'd8);
      check_eq({tag, "_prod"}, 64'(bus32.product), 64'(exp));
      check_eq({tag, "_rob"}, 64'(bus32.ROB_num_out), 64'(rob));
   endtask

   task automatic single16(input string tag, input logic [15:0] mc, input logic [15:0] mp,
                           input logic sgn, input logic hi, input logic [5:0] rob,
                           input logic [15:0] exp);
      int n;
      bus16.start = 1'b1; bus16.mcand = mc; bus16.mplier = mp; bus16.is_signed = sgn;
      bus16.high_sel = hi; bus16.ROB_num_in = rob; bus16.dest_PRN_in = 7'(rob);
      @(posedge clock); #1; bus16.start = 1'b0; n = 1;
      while (!bus16.done && n < 30) begin @(posedge clock); #1; n++; end
      check_eq({tag, "_lat"}, 64'(n), 64'd1);
      check_eq({tag, "_prod"}, 64'(bus16.product), 64'(exp));
      check_eq({tag, "_prn"}, 64'(bus16.dest_PRN_out), 64'(rob));
   endtask

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

   logic [63:0] bb_mc  [4];
   logic [63:0] bb_mp  [4];
   logic        bb_sgn [4];
   logic        bb_hi  [4];
   logic [63:0] bb_exp [4];

   initial begin
      int   n;
      logic seen;
      logic [63:0] held;

      bus64.enable = 1'b1; bus64.flush = 1'b0; bus64.start = 1'b0;
      bus64.mcand = '0; bus64.mplier = '0; bus64.is_signed = 1'b0; bus64.high_sel = 1'b0;
      bus64.ROB_num_in = '0; bus64.dest_PRN_in = '0;
      bus32.enable = 1'b1; bus32.flush = 1'b0; bus32.start = 1'b0;
      bus32.mcand = '0; bus32.mplier = '0; bus32.is_signed = 1'b0; bus32.high_sel = 1'b0;
      bus32.ROB_num_in = '0; bus32.dest_PRN_in = '0;
      bus16.enable = 1'b1; bus16.flush = 1'b0; bus16.start = 1'b0;
      bus16.mcand = '0; bus16.mplier = '0; bus16.is_signed = 1'b0; bus16.high_sel = 1'b0;
      bus16.ROB_num_in = '0; bus16.dest_PRN_in = '0;

      bb_mc[0] = ONES; bb_mp[0] = 64'd2; bb_sgn[0] = 1'b0; bb_hi[0] = 1'b0; bb_exp[0] = 64'hFFFF_FFFF_FFFF_FFFE;
      bb_mc[1] = ONES; bb_mp[1] = 64'd2; bb_sgn[1] = 1'b0; bb_hi[1] = 1'b1; bb_exp[1] = 64'h1;
      bb_mc[2] = ONES; bb_mp[2] = 64'd2; bb_sgn[2] = 1'b1; bb_hi[2] = 1'b1; bb_exp[2] = ONES;
      bb_mc[3] = MIN;  bb_mp[3] = MIN;   bb_sgn[3] = 1'b1; bb_hi[3] = 1'b1; bb_exp[3] = 64'h4000_0000_0000_0000;

      // Reset state
      #12;
      check_eq("rst_done", 64'(bus64.done), 64'd0);
      check_eq("rst_busy", 64'(bus64.busy), 64'd0);
      check_eq("rst_prod", bus64.product, 64'd0);
      check_eq("rst_rob", 64'(bus64.ROB_num_out), 64'd0);
      check_eq("rst_prn", 64'(bus64.dest_PRN_out), 64'd0);
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;

      // Basic 64/4 vectors
      single64("u_lo", ONES, 64'd2, 1'b0, 1'b0, 6'd5, 7'd9,  64'hFFFF_FFFF_FFFF_FFFE);
      single64("u_hi", ONES, 64'd2, 1'b0, 1'b1, 6'd6, 7'd10, 64'h1);
      single64("s_lo", ONES, 64'd2, 1'b1, 1'b0, 6'd7, 7'd11, 64'hFFFF_FFFF_FFFF_FFFE);
      single64("s_hi", ONES, 64'd2, 1'b1, 1'b1, 6'd8, 7'd12, ONES);
      single64("s_min", MIN, MIN,   1'b1, 1'b1, 6'd9, 7'd13, 64'h4000_0000_0000_0000);

      // Back-to-back, mixed modes
      for (int k = 0; k < 4; k++) begin
         op64(bb_mc[k], bb_mp[k], bb_sgn[k], bb_hi[k], 6'(k + 1), 7'(k + 20));
         @(posedge clock); #1;
      end
      bus64.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("bb%0d_done", k), 64'(bus64.done), 64'd1);
         check_eq($sformatf("bb%0d_rob", k), 64'(bus64.ROB_num_out), 64'(k + 1));
         check_eq($sformatf("bb%0d_prod", k), bus64.product, bb_exp[k]);
         @(posedge clock); #1;
      end
      check_eq("bb_end", 64'(bus64.done), 64'd0);

      // Stall of 3 cycles right after capture, then stall while done is high
      op64(ONES, 64'd3, 1'b0, 1'b0, 6'd15, 7'd16);
      @(posedge clock); #1; bus64.start = 1'b0; bus64.enable = 1'b0; n = 1;
      repeat (3) begin @(posedge clock); #1; n++; end
      check_eq("stall_nodone", 64'(bus64.done), 64'd0);
      bus64.enable = 1'b1;
      while (!bus64.done && n < 30) begin @(posedge clock); #1; n++; end
      check_eq("stall_lat", 64'(n), 64'd7);
      check_eq("stall_prod", bus64.product, 64'hFFFF_FFFF_FFFF_FFFD);
      held = bus64.product;
      bus64.enable = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      check_eq("hold_done", 64'(bus64.done), 64'd1);
      check_eq("hold_prod", bus64.product, held);
      bus64.enable = 1'b1;
      @(posedge clock); #1;
      check_eq("hold_release", 64'(bus64.done), 64'd0);

      // Flush with three in flight plus a same-cycle start
      for (int k = 0; k < 3; k++) begin
         op64(ONES, 64'd2, 1'b0, 1'b0, 6'(30 + k), 7'(30 + k));
         @(posedge clock); #1;
      end
      op64(ONES, 64'd2, 1'b0, 1'b0, 6'd33, 7'd33);
      bus64.flush = 1'b1;
      @(posedge clock); #1;
      bus64.flush = 1'b0; bus64.start = 1'b0;
      check_eq("flush_busy", 64'(bus64.busy), 64'd0);
      check_eq("flush_done", 64'(bus64.done), 64'd0);
      single64("post_flush", 64'd7, 64'd6, 1'b0, 1'b0, 6'd40, 7'd41, 64'd42);
      seen = 1'b0;
      repeat (6) begin @(posedge clock); #1; if (bus64.done) seen = 1'b1; end
      check_eq("flush_stale", 64'(seen), 64'd0);

      // Async reset mid-flight
      op64(ONES, 64'd2, 1'b0, 1'b0, 6'd50, 7'd51);
      @(posedge clock); #1;
      op64(ONES, 64'd2, 1'b0, 1'b1, 6'd52, 7'd53);
      @(posedge clock); #1; bus64.start = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      check_eq("pre_rst_done", 64'(bus64.done), 64'd1);
      reset = 1'b0; #1;
      check_eq("mid_rst_done", 64'(bus64.done), 64'd0);
      check_eq("mid_rst_busy", 64'(bus64.busy), 64'd0);
      check_eq("mid_rst_prod", bus64.product, 64'd0);
      check_eq("mid_rst_rob", 64'(bus64.ROB_num_out), 64'd0);
      check_eq("mid_rst_prn", 64'(bus64.dest_PRN_out), 64'd0);
      @(negedge clock); reset = 1'b1;
      seen = 1'b0;
      repeat (8) begin @(posedge clock); #1; if (bus64.done) seen = 1'b1; end
      check_eq("rst_stale", 64'(seen), 64'd0);

      // 32/8 build
      single32("w32_u_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'd1, 32'h0000_0001);
      single32("w32_u_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 6'd2, 32'hFFFF_FFFE);
      single32("w32_s_lo", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 6'd3, 32'hFFFF_FFF1);
      single32("w32_s_hi", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 6'd4, 32'hFFFF_FFFF);
      single32("w32_u_sh", 32'h1234_5678, 32'h10, 1'b0, 1'b1, 6'd5, 32'h1);

      // 16/1 build
      single16("w16_u_hi", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 6'd11, 16'hFFFE);
      single16("w16_s_hi", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 6'd12, 16'h0000);
      single16("w16_s_lo", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 6'd13, 16'h0001);
      single16("w16_mn_hi", 16'h8000, 16'h7FFF, 1'b1, 1'b1, 6'd14, 16'hC000);
      single16("w16_mn_lo", 16'h8000, 16'h7FFF, 1'b1, 1'b0, 6'd15, 16'h8000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mult_pipe_param.md
# mult_pipe_param

Parametrised, stallable, flushable pipelined integer multiplier for the out-of-order core's multiply functional unit. It accepts one multiply per cycle and returns either the low or the high half of the full 2×WIDTH product. Signed and unsigned operands are both supported. The ROB number and destination PRN are carried alongside each operation. The entire pipeline can be squashed on a branch mispredict or exception.

## Interface
Parameters:
- WIDTH, 64, operand and result width
- STAGES, 4, pipeline depth; must divide WIDTH evenly, range 1..WIDTH
- ROB_W, 6, ROB tag width
- PRN_W, 7, physical register tag width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- enable  in  1  1 = pipeline advances; 0 = every stage holds
- flush  in  1  synchronous squash of all in-flight and incoming ops
- start  in  1  launch a multiply this cycle
- mcand  in  WIDTH  multiplicand
- mplier  in  WIDTH  multiplier
- is_signed  in  1  0 = unsigned×unsigned, 1 = signed×signed (two's complement)
- high_sel  in  1  0 = return P[WIDTH-1:0], 1 = return P[2*WIDTH-1:WIDTH]
- ROB_num_in  in  ROB_W  tag carried with the op
- dest_PRN_in  in  PRN_W  tag carried with the op
- product  out  WIDTH  selected half of the product
- ROB_num_out  out  ROB_W  tag of the completing op
- dest_PRN_out  out  PRN_W  tag of the completing op
- done  out  1  result valid
- busy  out  1  OR of all stage valid bits

## Operation
- P is the exact 2×WIDTH product of mcand and mplier, with the operands interpreted according to is_signed.
- Each stage consumes WIDTH/STAGES bits of the multiplier, LSB-first, and adds the shifted multiplicand partial to a 2×WIDTH accumulator.
- Signed mode is implemented by sign-extending both operands to 2×WIDTH, or by an equivalent correction term. Any method is acceptable if the result is bit-exact.
- Each stage registers: valid, accumulator, remaining multiplier, shifted multiplicand, is_signed, high_sel, ROB tag and PRN tag.
- The half select is applied at the final stage output only.
- Stage 0 captures an op when start=1, enable=1 and flush=0.
- When enable=0, every stage register holds, including done and the output tags. A consumer accepts a result only when done=1 and enable=1.
- When flush=1 at a rising edge, every valid bit clears regardless of enable, and any start in that cycle is dropped. Data registers need not clear.
- Async reset clears all valid bits, done, busy, product, ROB_num_out and dest_PRN_out to 0. Internal data registers need no reset.
- The next op may start the cycle after reset deasserts.

## Timing
- Latency: an op captured at enabled edge N has done=1 after enabled edge N+STAGES-1, i.e. after STAGES enabled edges counting the capture edge. Edges with enable=0 add delay one-for-one.
- Throughput: one op per enabled cycle, with no bubbles. Back-to-back starts produce back-to-back done.
- done lasts one enabled cycle per op. With enable=0 it stays high until the next enabled edge.
- A STAGES=1 build is a single registered multiply: done follows the capture edge directly.
- Reset asserted mid-operation takes effect immediately and asynchronously: all in-flight ops are lost, and no done is produced for them after release.
- flush and start in the same cycle: nothing is captured, and the pipeline is empty after the edge.
- enable=0 and flush=1 in the same cycle: the flush wins, so all valids clear.
- Tags and the half select travel with their own op. Consecutive ops with different is_signed, high_sel and tag values never mix.

## Test plan
- Defaults (64/4). Unsigned 0xFFFF_FFFF_FFFF_FFFF × 2, high_sel=0 → product 0xFFFF_FFFF_FFFF_FFFE. With high_sel=1 → product 0x1. done appears 4 edges after capture; ROB and PRN tags match the inputs.
- Signed −1 × 2: high_sel=0 → 0xFFFF_FFFF_FFFF_FFFE; high_sel=1 → 0xFFFF_FFFF_FFFF_FFFF. Signed 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000 with high_sel=1 → 0x4000_0000_0000_0000.
- Four back-to-back starts with ROB tags 1,2,3,4 and mixed modes → done high for 4 consecutive cycles, with tags 1,2,3,4 in order and each result correct for its own mode.
- Launch one op, then drop enable for 3 cycles after the first capture edge → done is delayed by exactly 3 cycles. If the stall occurs while done=1, done and product hold steady.
- Launch 3 ops, then assert flush for one cycle together with a new start → no done for any of the 4 ops, and busy=0 after the flush edge. A fresh op started on the next cycle completes normally. Separately, assert reset mid-flight → all outputs are 0 immediately, and no stale done follows.
- Random sweep for builds WIDTH=32/STAGES=8 and WIDTH=16/STAGES=1 → every result matches the reference-model 2×WIDTH product half, for both signed and unsigned operands.
